// File: rtl/serial_subtractor_4b.sv
// ---------------------------------------------------------------------------
// serial_subtractor_4b
//
// Bit-serial decode/check stage for the ripple adder: given the adder's
// WIDTH+1 bit sum and one WIDTH-bit addend, recovers the other addend
// b = sum - a, one bit per clock (LSB first) through a single
// full-subtractor cell with a registered borrow.
//
// Ports:
//   clk    in   1        rising-edge clock
//   rst    in   1        asynchronous, active-high reset
//   start  in   1        request, sampled only while idle
//   sum    in   WIDTH+1  minuend, captured on an accepted start
//   a      in   WIDTH    subtrahend, captured on an accepted start
//   busy   out  1        high while a subtraction is in flight or completing
//   done   out  1        one-cycle pulse; b/err valid from this cycle
//   b      out  WIDTH    recovered addend, held until the next completion
//   err    out  1        underflow (sum < a) or result wider than WIDTH bits
// ---------------------------------------------------------------------------
module serial_subtractor_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] b,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH:0]   s_sh_reg;
    logic [WIDTH:0]   a_sh_reg;
    logic [WIDTH:0]   d_sh_reg;
    logic             br_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] b_reg;
    logic             err_reg;

    // Full-subtractor cell on the current LSBs
    logic           x_bit;
    logic           y_bit;
    logic           d_bit;
    logic           br_next;
    logic [WIDTH:0] d_sh_next;
    logic           last_step;

    always_comb begin
        x_bit     = s_sh_reg[0];
        y_bit     = a_sh_reg[0];
        d_bit     = x_bit ^ y_bit ^ br_reg;
        br_next   = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_reg);
        // New bit enters at the MSB so after WIDTH+1 steps the LSB
        // computed first has walked down to bit 0.
        d_sh_next = {d_bit, d_sh_reg[WIDTH:1]};
        last_step = (cnt_reg == CW'(WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            s_sh_reg  <= '0;
            a_sh_reg  <= '0;
            d_sh_reg  <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            b_reg     <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        s_sh_reg  <= sum;
                        a_sh_reg  <= {1'b0, a};
                        d_sh_reg  <= '0;
                        br_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    d_sh_reg <= d_sh_next;
                    br_reg   <= br_next;
                    s_sh_reg <= {1'b0, s_sh_reg[WIDTH:1]};
                    a_sh_reg <= {1'b0, a_sh_reg[WIDTH:1]};
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (last_step) begin
                        // Results come straight from the completed difference
                        // and the borrow out of the top bit, so they are
                        // valid in the same cycle done rises.
                        b_reg     <= d_sh_next[WIDTH-1:0];
                        err_reg   <= br_next | d_sh_next[WIDTH];
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Pure decodes of registered state; no input reaches an output
    // without passing through a flop.
    assign busy = (state_reg == SHIFT) || (state_reg == DONE);
    assign done = (state_reg == DONE);
    assign b    = b_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_serial_subtractor_4b.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_4b
//
// Self-checking bench for serial_subtractor_4b. A cycle model of the
// handshake decides when a start is accepted, pushes the expected result
// into a scoreboard queue, and pops it in the cycle the result must appear.
// busy/done/b/err are compared against the model on every falling edge.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_4b;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH:0]   sum = '0;
    logic [WIDTH-1:0] a = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] b;
    logic             err;

    serial_subtractor_4b #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sum   (sum),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .b     (b),
        .err   (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             e;
    } txn_t;

    txn_t sb[$];

    // Model state: 0 idle, 1..5 shifting, 6 done cycle
    int               phase = 0;
    logic [WIDTH-1:0] exp_b = '0;
    logic             exp_err = 1'b0;
    int               accepts = 0;

    function automatic txn_t make_txn(input logic [WIDTH:0] s_in, input logic [WIDTH-1:0] a_in);
        txn_t t;
        int   sv;
        int   av;
        int   dv;
        sv  = int'(s_in);
        av  = int'(a_in);
        dv  = sv - av;
        t.s = s_in;
        t.a = a_in;
        t.b = WIDTH'((dv + 64) % 16);
        t.e = (sv < av) || (dv > 15);
        return t;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   = 0;
            exp_b   = '0;
            exp_err = 1'b0;
            sb.delete();
        end else if (phase == 0) begin
            if (start === 1'b1) begin
                sb.push_back(make_txn(sum, a));
                accepts++;
                phase = 1;
            end
        end else if (phase < 6) begin
            phase++;
            if (phase == 6) begin
                if (sb.size() == 0) begin
                    chk("sb_underrun", 32'd1, 32'd0);
                end else begin
                    txn_t t;
                    t       = sb.pop_front();
                    exp_b   = t.b;
                    exp_err = t.e;
                    $display("txn sum=%0d a=%0d -> b=%0d err=%0b (dut b=%0d err=%0b)",
                             t.s, t.a, t.b, t.e, b, err);
                end
            end
        end else begin
            phase = 0;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(phase != 0));
        chk("done", 32'(done), 32'(phase == 6));
        chk("b",    32'(b),    32'(exp_b));
        chk("err",  32'(err),  32'(exp_err));
    end

    // One transaction: start high for a single edge, operands scrambled
    // right after acceptance, then wait until the unit is idle again.
    task automatic run(input logic [WIDTH:0] s_in, input logic [WIDTH-1:0] a_in);
        @(negedge clk);
        sum   = s_in;
        a     = a_in;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sum   = 5'($urandom);
        a     = 4'($urandom);
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             e;
    } vec_t;

    vec_t dir_tab[6] = '{
        '{5'b10000, 4'b0110, 4'b1010, 1'b0},
        '{5'b10101, 4'b0111, 4'b1110, 1'b0},
        '{5'b11110, 4'b1111, 4'b1111, 1'b0},
        '{5'b00011, 4'b0101, 4'b1110, 1'b1},
        '{5'b11111, 4'b0000, 4'b1111, 1'b1},
        '{5'b00000, 4'b0000, 4'b0000, 1'b0}
    };

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed vectors, issued back-to-back
        for (int i = 0; i < 6; i++) begin
            run(dir_tab[i].s, dir_tab[i].a);
            chk($sformatf("dir%0d_b", i), 32'(b), 32'(dir_tab[i].b));
            chk($sformatf("dir%0d_err", i), 32'(err), 32'(dir_tab[i].e));
        end

        // start held high with operands changing every cycle
        begin
            int acc0;
            acc0 = accepts;
            @(negedge clk);
            start = 1'b1;
            for (int i = 0; i < 40; i++) begin
                sum = 5'($urandom);
                a   = 4'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
            repeat (8) @(negedge clk);
            chk("held_start_accepts", 32'(accepts - acc0 >= 5), 32'd1);
        end

        // Asynchronous reset two cycles into the shift phase
        run(5'd13, 4'd2);
        @(negedge clk);
        sum   = 5'd9;
        a     = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_b",    32'(b),    32'd0);
        chk("rst_err",  32'(err),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(5'b00110, 4'b0010);
        chk("post_rst_b",   32'(b),   32'd4);
        chk("post_rst_err", 32'(err), 32'd0);

        // Exhaustive sweep
        for (int s = 0; s < 32; s++) begin
            for (int k = 0; k < 16; k++) begin
                run(5'(s), 4'(k));
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
